sipo_deframer: RTL and testbench
================================

# sipo_deframer

Serial-to-parallel receive stage that consumes the 1-bit stream produced by the PISO shifter. It detects a start bit, shifts in a W-bit word MSB first, and optionally checks an even-parity bit. The completed word is presented on a registered valid/ready output port with parity-error and overrun status. The block sits directly downstream of the PISO and feeds parallel consumers such as registers or a FIFO.

## Interface
- W, default 4: data word width in bits; legal range 2–16.
- PARITY_EN, default 0: 1 means an even-parity bit follows the data bits; 0 means no parity bit.
- clk  in  1  single clock; all logic is clocked on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- sin  in  1  serial data from the PISO `q`.
- sin_en  in  1  bit strobe; `sin` is sampled only on edges where `sin_en=1`.
- dout  out  W  received word, valid while `dout_valid=1`.
- dout_valid  out  1  word available.
- dout_ready  in  1  consumer accepts the word.
- perr  out  1  parity error for the current `dout`; qualified by `dout_valid`; always 0 when PARITY_EN=0.
- overrun  out  1  sticky flag: a completed word was dropped because the output was still occupied.
- ovr_clr  in  1  clears `overrun`.

## Operation
- FSM states are IDLE, DATA, PAR.
- IDLE: on an edge with `sin_en=1` and `sin=1` (start bit), go to DATA, clear the shift register, and set bit counter = 0. `sin=0` in IDLE is line idle and is ignored.
- DATA: on each edge with `sin_en=1`, shift `sin` in MSB first (`shreg <= {shreg[W-2:0], sin}`) and increment the counter.
  - On the W-th bit: go to PAR if PARITY_EN=1; otherwise complete the word and return to IDLE.
- PAR: on an edge with `sin_en=1`, sample the parity bit, complete the word, and return to IDLE.
  - perr = ^{data, parity_bit}, i.e. set when the total count of ones is odd.
- `sin_en=0` in any state: state, counter and shift register hold (the frame pauses).
- Word completion:
  - If `dout_valid=0`, or `dout_ready=1` on the same edge: load `dout`/`perr` and set `dout_valid=1`.
  - Otherwise: keep the old word, drop the new one, and set `overrun=1`.
- Handshake: the word transfers on an edge where `dout_valid && dout_ready`. `dout_valid` falls after that edge unless a new word completes on the same edge; in that case `dout_valid` stays 1 and `dout` takes the new value.
- `dout` and `perr` stay stable while `dout_valid=1 && dout_ready=0`.
- A new frame may start in the cycle right after word completion. The receiver keeps running while the output is occupied.
- `overrun` is sticky until `ovr_clr=1`. If set and clear occur on the same edge, set wins.

## Timing
- Reset (edge with `rst_n=0`): state=IDLE, counter=0, shreg=0, dout=0, dout_valid=0, perr=0, overrun=0. Reset overrides all other inputs.
- Reset mid-frame discards the partial word. The first start bit after `rst_n` rises begins a fresh frame.
- Latency: the final bit (last data bit, or parity) is sampled at edge N; `dout_valid=1` and `dout` are visible after edge N.
- Frame length in strobed bits: 1 + W + PARITY_EN. Minimum time between words is that many cycles with `sin_en` held at 1.
- All outputs are registered; there are no combinational paths from input to output.
- `dout_ready` may be held high constantly; the block then never overruns.

## Structure
- Package `sipo_pkg` holds:
  - the state enum `sipo_state_t` (IDLE, DATA, PAR);
  - the counter width function `clog2(W+1)`;
  - the parity-mode constants PAR_NONE=0 and PAR_EVEN=1.
- One sub-module, `sipo_shreg`: W-bit shift register with enable, synchronous clear and MSB-first serial input, reset by the same `rst_n`.
- The top level contains the FSM, bit counter, output holding register, and flag logic.

## Test plan
- W=4, PARITY_EN=0, `dout_ready=1`: drive `sin` = 1,1,0,1,1 with `sin_en=1` → `dout=4'b1011`, `dout_valid=1` for 1 cycle after the 5th edge, perr=0.
- PARITY_EN=1: send start, data 1011, parity 1 → dout=1011, perr=0. Repeat with parity 0 → perr=1.
- Insert `sin_en=0` gaps of 3 cycles between bits of a frame carrying 0110 → `dout=4'b0110`, with no extra bits shifted during the gaps.
- `dout_ready=0`: send two frames (1011, then 0001) → dout holds 1011, overrun=1. `ovr_clr` pulse → overrun=0. `dout_ready=1` → valid falls.
- Assert `rst_n=0` after the 2nd data bit, then release and send frame 1100 → dout=1100 with no residue from the aborted frame; all outputs read 0 during reset.
- Back-to-back frames with `dout_ready` pulsed on the completion edge → valid stays 1 and `dout` updates from 1011 to 0101 without a gap.

Source files
------------

// File: rtl/sipo_deframer_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared types and helpers for the serial-to-parallel deframer.
//   sipo_state_t : receive FSM state encoding (IDLE, DATA, PAR)
//   PAR_NONE     : no parity bit follows the data bits
//   PAR_EVEN     : an even-parity bit follows the data bits
//   cnt_width()  : width of a counter that must hold the values 0..w
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } sipo_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_deframer_if.sv
// -----------------------------------------------------------------------------
// sipo_deframer_if
// Bundles the serial input, the parallel valid/ready output and the overrun
// status of the deframer.
//   sin, sin_en      : serial bit and its sampling strobe
//   dout, dout_valid : received word and its valid flag
//   dout_ready       : consumer accepts the word
//   perr             : parity error for the current dout
//   overrun, ovr_clr : sticky dropped-word flag and its clear
// modport master : the deframer side
// modport slave  : the producer/consumer side
// -----------------------------------------------------------------------------
interface sipo_deframer_if #(
    parameter int W = 4
);
    logic         sin;
    logic         sin_en;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         perr;
    logic         overrun;
    logic         ovr_clr;

    modport master (
        input  sin, sin_en, dout_ready, ovr_clr,
        output dout, dout_valid, perr, overrun
    );

    modport slave (
        output sin, sin_en, dout_ready, ovr_clr,
        input  dout, dout_valid, perr, overrun
    );
endinterface

// File: rtl/sipo_deframer_shreg.sv
// -----------------------------------------------------------------------------
// sipo_shreg
// W-bit shift register, MSB-first serial input. Clear has priority over shift.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear
//   en         : shift enable
//   din        : serial input, enters at bit 0
//   q          : parallel contents
// -----------------------------------------------------------------------------
module sipo_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// -----------------------------------------------------------------------------
// sipo_deframer
// Receives start bit + W data bits (MSB first) + optional even-parity bit from
// a PISO stream and presents the word on a registered valid/ready port.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sipo_deframer_if.master (serial in, parallel out, status)
//
//   state | meaning
//   IDLE  | waiting for a start bit (sin=1 on a strobe)
//   DATA  | shifting in data bits, cnt counts bits received
//   PAR   | waiting for the parity bit
// -----------------------------------------------------------------------------
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int W         = 4,
    parameter int PARITY_EN = PAR_NONE
) (
    input  logic             clk,
    input  logic             rst_n,
    sipo_deframer_if.master  bus
);

    localparam int CW = cnt_width(W);

    sipo_state_t   state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shreg_q;
    logic [W-1:0]  dout_q;
    logic          valid_q;
    logic          perr_q;
    logic          overrun_q;

    logic          shreg_clr;
    logic          shreg_en;
    logic          last_data;
    logic          done;
    logic [W-1:0]  word;
    logic          word_perr;

    sipo_shreg #(.W(W)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (shreg_clr),
        .en    (shreg_en),
        .din   (bus.sin),
        .q     (shreg_q)
    );

    // Without parity the word completes on the last data bit, so the
    // completed word is the shift register contents plus the bit arriving now.
    always_comb begin
        shreg_clr = (state == IDLE) && bus.sin_en && bus.sin;
        shreg_en  = (state == DATA) && bus.sin_en;
        last_data = shreg_en && (cnt == CW'(W - 1));
        done      = 1'b0;
        word      = shreg_q;
        word_perr = 1'b0;
        if (last_data && (PARITY_EN == PAR_NONE)) begin
            done = 1'b1;
            word = {shreg_q[W-2:0], bus.sin};
        end
        if ((state == PAR) && bus.sin_en) begin
            done      = 1'b1;
            word      = shreg_q;
            word_perr = ^{shreg_q, bus.sin};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (shreg_clr) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (bus.sin_en) begin
                        cnt <= cnt + 1'b1;
                        if (last_data) begin
                            state <= (PARITY_EN == PAR_EVEN) ? PAR : IDLE;
                        end
                    end
                end
                PAR: begin
                    if (bus.sin_en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A completing word may replace one being accepted on this edge,
            // which keeps valid high with no bubble.
            if (done && (!valid_q || bus.dout_ready)) begin
                dout_q  <= word;
                perr_q  <= word_perr;
                valid_q <= 1'b1;
            end else if (valid_q && bus.dout_ready) begin
                valid_q <= 1'b0;
            end

            // Set beats clear on the same edge.
            if (done && valid_q && !bus.dout_ready) begin
                overrun_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.perr       = perr_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deframer
// Directed bench for sipo_deframer: one instance without parity (b0) and one
// with even parity (b1), W=4 for both, sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_sipo_deframer;
    import sipo_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sipo_deframer_if #(.W(4)) b0 ();
    sipo_deframer_if #(.W(4)) b1 ();

    sipo_deframer #(.W(4), .PARITY_EN(PAR_NONE)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.master)
    );

    sipo_deframer #(.W(4), .PARITY_EN(PAR_EVEN)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bits are sent from bit n-1 down to bit 0; during gaps sin is held at 1
    // so any wrongly sampled gap cycle would corrupt the word.
    task automatic send0(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            b0.sin    = bits[i];
            b0.sin_en = 1'b1;
            tick();
            b0.sin_en = 1'b0;
            b0.sin    = 1'b1;
            if (i > 0) repeat (gap) tick();
        end
    endtask

    task automatic send1(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            b1.sin    = bits[i];
            b1.sin_en = 1'b1;
            tick();
            b1.sin_en = 1'b0;
            b1.sin    = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        b0.sin = 1'b0; b0.sin_en = 1'b0; b0.dout_ready = 1'b1; b0.ovr_clr = 1'b0;
        b1.sin = 1'b0; b1.sin_en = 1'b0; b1.dout_ready = 1'b1; b1.ovr_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_dout0",  32'(b0.dout),       32'h0);
        check("rst_valid0", 32'(b0.dout_valid), 32'h0);
        check("rst_perr0",  32'(b0.perr),       32'h0);
        check("rst_ovr0",   32'(b0.overrun),    32'h0);
        check("rst_dout1",  32'(b1.dout),       32'h0);
        check("rst_valid1", 32'(b1.dout_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic frame, no parity
        send0(16'b11011, 5, 0);
        check("t1_valid", 32'(b0.dout_valid), 32'h1);
        check("t1_dout",  32'(b0.dout),       32'hB);
        check("t1_perr",  32'(b0.perr),       32'h0);
        tick();
        check("t1_valid_fall", 32'(b0.dout_valid), 32'h0);

        // Even parity: good then bad
        send1(16'b110111, 6);
        check("t2_valid", 32'(b1.dout_valid), 32'h1);
        check("t2_dout",  32'(b1.dout),       32'hB);
        check("t2_perr",  32'(b1.perr),       32'h0);
        send1(16'b110110, 6);
        check("t2_dout_bad", 32'(b1.dout), 32'hB);
        check("t2_perr_bad", 32'(b1.perr), 32'h1);

        // Strobe gaps of 3 cycles between bits
        send0(16'b10110, 5, 3);
        check("t3_valid", 32'(b0.dout_valid), 32'h1);
        check("t3_dout",  32'(b0.dout),       32'h6);
        tick();

        // Overrun with consumer stalled
        b0.dout_ready = 1'b0;
        send0(16'b11011, 5, 0);
        check("t4_valid_a", 32'(b0.dout_valid), 32'h1);
        check("t4_dout_a",  32'(b0.dout),       32'hB);
        check("t4_ovr_a",   32'(b0.overrun),    32'h0);
        send0(16'b10001, 5, 0);
        check("t4_dout_hold", 32'(b0.dout),       32'hB);
        check("t4_valid_b",   32'(b0.dout_valid), 32'h1);
        check("t4_ovr_set",   32'(b0.overrun),    32'h1);
        b0.ovr_clr = 1'b1;
        tick();
        b0.ovr_clr = 1'b0;
        check("t4_ovr_clr",   32'(b0.overrun), 32'h0);
        check("t4_dout_hold2", 32'(b0.dout),   32'hB);
        b0.dout_ready = 1'b1;
        tick();
        check("t4_valid_fall", 32'(b0.dout_valid), 32'h0);

        // Reset after the second data bit
        send0(16'b110, 3, 0);
        rst_n = 1'b0;
        tick();
        check("t5_rst_dout0",  32'(b0.dout),       32'h0);
        check("t5_rst_valid0", 32'(b0.dout_valid), 32'h0);
        check("t5_rst_perr0",  32'(b0.perr),       32'h0);
        check("t5_rst_ovr0",   32'(b0.overrun),    32'h0);
        check("t5_rst_dout1",  32'(b1.dout),       32'h0);
        check("t5_rst_perr1",  32'(b1.perr),       32'h0);
        rst_n = 1'b1;
        tick();
        send0(16'b11100, 5, 0);
        check("t5_valid", 32'(b0.dout_valid), 32'h1);
        check("t5_dout",  32'(b0.dout),       32'hC);
        check("t5_ovr",   32'(b0.overrun),    32'h0);
        tick();

        // Back-to-back with ready pulsed on the completion edge
        b0.dout_ready = 1'b0;
        send0(16'b11011, 5, 0);
        check("t6_dout_a", 32'(b0.dout), 32'hB);
        send0(16'b1010, 4, 0);
        check("t6_valid_hold", 32'(b0.dout_valid), 32'h1);
        check("t6_dout_hold",  32'(b0.dout),       32'hB);
        b0.dout_ready = 1'b1;
        b0.sin        = 1'b1;
        b0.sin_en     = 1'b1;
        tick();
        b0.sin_en     = 1'b0;
        b0.dout_ready = 1'b0;
        check("t6_valid_b2b", 32'(b0.dout_valid), 32'h1);
        check("t6_dout_b2b",  32'(b0.dout),       32'h5);
        check("t6_ovr",       32'(b0.overrun),    32'h0);
        b0.dout_ready = 1'b1;
        tick();
        check("t6_valid_fall", 32'(b0.dout_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
